// File: rtl/path_walker_pkg.sv
// Shared defaults and FSM state encodings for the path walker and the path ROM it reads.
package path_walker_pkg;

    localparam int T_DEF      = 64;
    localparam int LOG_T_DEF  = 6;
    localparam int PATH_W_DEF = 6;
    localparam int ACC_W_DEF  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } walk_state_e;

endpackage

// File: rtl/path_walker_if.sv
// ROM fetch and result bus between the path walker (slave) and its requester/ROM (master).
interface path_walker_if
    import path_walker_pkg::*;
#(
    parameter int LOG_T  = LOG_T_DEF,
    parameter int PATH_W = PATH_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic                    start;
    logic [LOG_T-1:0]        address;
    logic [PATH_W-1:0]       data;
    logic                    busy;
    logic                    valid;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] max_lvl;
    logic signed [ACC_W-1:0] min_lvl;

    modport master (
        output start, data,
        input  address, busy, valid, sum, max_lvl, min_lvl
    );

    modport slave (
        input  start, data,
        output address, busy, valid, sum, max_lvl, min_lvl
    );
endinterface

// File: rtl/path_walker_stats.sv
// Path level accumulator with running max/min. Define PATH_WALKER_SATURATE_EN to clamp
// each add to the signed accumulator range; otherwise the add wraps.
module path_walker_stats #(
    parameter int PATH_W = 6,
    parameter int ACC_W  = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [PATH_W-1:0]       data_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic signed [ACC_W-1:0] max_o,
    output logic signed [ACC_W-1:0] min_o
);
    logic signed [ACC_W-1:0] step_ext;
    logic signed [ACC_W-1:0] level;
    logic signed [ACC_W-1:0] sum_q, sum_d, max_q, max_d, min_q, min_d;

    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_ext
        if (gi < PATH_W) begin : g_bit
            assign step_ext[gi] = data_i[gi];
        end else begin : g_sign
            assign step_ext[gi] = data_i[PATH_W-1];
        end
    end

`ifdef PATH_WALKER_SATURATE_EN
    logic signed [ACC_W:0] wide;
    always_comb begin
        wide = {sum_q[ACC_W-1], sum_q} + {step_ext[ACC_W-1], step_ext};
        // Top two bits disagree only when the add left the ACC_W-bit range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            level = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            level = wide[ACC_W-1:0];
        end
    end
`else
    assign level = sum_q + step_ext;
`endif

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        min_d = min_q;
        if (clr_i) begin
            sum_d = '0;
            max_d = '0;
            min_d = '0;
        end else if (en_i) begin
            sum_d = level;
            if (level > max_q) max_d = level;
            if (level < min_q) min_d = level;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            max_q <= '0;
            min_q <= '0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign sum_o = sum_q;
    assign max_o = max_q;
    assign min_o = min_q;
endmodule

// File: rtl/path_walker.sv
// Sweeps the path ROM once per start and reports final/max/min path level with a valid pulse.
// Optional clamping of the running level is enabled with PATH_WALKER_SATURATE_EN.
module path_walker
    import path_walker_pkg::*;
#(
    parameter int T      = T_DEF,
    parameter int LOG_T  = LOG_T_DEF,
    parameter int PATH_W = PATH_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    path_walker_if.slave bus
);
    walk_state_e      state_q, state_d;
    logic [LOG_T-1:0] addr_q, addr_d;
    logic             dvalid_q;
    logic             clr;
    logic signed [ACC_W-1:0] sum_w, max_w, min_w;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (bus.start) begin
                    state_d = ST_FETCH;
                    clr     = 1'b1;
                end
            end
            ST_FETCH: begin
                // Address counter wraps back to 0 as the last address is issued.
                addr_d = addr_q + 1'b1;
                if (addr_q == LOG_T'(T - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dvalid_q <= (state_q == ST_FETCH);
        end
    end

    path_walker_stats #(
        .PATH_W (PATH_W),
        .ACC_W  (ACC_W)
    ) u_stats (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .en_i   (dvalid_q),
        .data_i (bus.data),
        .sum_o  (sum_w),
        .max_o  (max_w),
        .min_o  (min_w)
    );

    assign bus.address = addr_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.valid   = (state_q == ST_DONE);
    assign bus.sum     = sum_w;
    assign bus.max_lvl = max_w;
    assign bus.min_lvl = min_w;
endmodule

// File: tb/tb_path_walker.sv
// Drives a 12-bit and an 8-bit accumulator walker from one registered ROM model and
// checks each walk against a step-by-step path model.
module tb_path_walker;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [5:0] rom [T];

    int n_checks = 0;
    int n_fail   = 0;

    int got_sum [2];
    int got_max [2];
    int got_min [2];
    bit got_v8;
    bit post_valid, post_busy, busy_gap;
    int addr_seen [$];

    always #5 clk = ~clk;

    path_walker_if #(.LOG_T(6), .PATH_W(6), .ACC_W(12)) bus12 ();
    path_walker_if #(.LOG_T(6), .PATH_W(6), .ACC_W(8))  bus8 ();

    assign bus12.start = start;
    assign bus8.start  = start;

    always @(posedge clk) begin
        bus12.data <= rom[bus12.address];
        bus8.data  <= rom[bus8.address];
    end

    path_walker #(.T(T), .LOG_T(6), .PATH_W(6), .ACC_W(12)) dut12 (
        .clk_i (clk), .rst_i (rst), .bus (bus12.slave)
    );
    path_walker #(.T(T), .LOG_T(6), .PATH_W(6), .ACC_W(8)) dut8 (
        .clk_i (clk), .rst_i (rst), .bus (bus8.slave)
    );

    function automatic int fold(input int v, input int w);
        int m = 1 << w;
        int r = ((v % m) + m) % m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Walk the ROM as a list of signed increments; w is the accumulator width.
    function automatic void model(input int w, output int s, output int mx, output int mn);
        int lo = -(1 << (w - 1));
        int hi = (1 << (w - 1)) - 1;
        bit sat;
`ifdef PATH_WALKER_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        s = 0; mx = 0; mn = 0;
        for (int k = 0; k < T; k++) begin
            int d = (rom[k] >= 32) ? int'(rom[k]) - 64 : int'(rom[k]);
            s = s + d;
            if (sat) s = (s > hi) ? hi : ((s < lo) ? lo : s);
            else     s = fold(s, w);
            if (s > mx) mx = s;
            if (s < mn) mn = s;
        end
    endfunction

    task automatic run_walk(input bit hold, output int vcyc);
        vcyc = -1;
        busy_gap = 1'b0;
        addr_seen.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            #1;
            if (!hold) start = 1'b0;
            if (c <= T) addr_seen.push_back(int'(bus12.address));
            if (bus12.valid) begin
                vcyc = c;
                got_sum[0] = int'(bus12.sum);  got_sum[1] = int'(bus8.sum);
                got_max[0] = int'(bus12.max_lvl); got_max[1] = int'(bus8.max_lvl);
                got_min[0] = int'(bus12.min_lvl); got_min[1] = int'(bus8.min_lvl);
                got_v8 = bus8.valid;
                break;
            end
            if (!bus12.busy) busy_gap = 1'b1;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        post_valid = bus12.valid;
        post_busy  = bus12.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus12.busy, bus12.valid, bus8.busy, bus8.valid} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy/valid %b, want 0000",
                {bus12.busy, bus12.valid, bus8.busy, bus8.valid});
        end
        n_checks++;
        if (bus12.address !== 6'd0 || bus12.sum !== 12'sd0 || bus12.max_lvl !== 12'sd0 || bus12.min_lvl !== 12'sd0) begin
            n_fail++; $display("FAIL reset_values: addr=%0d sum=%0d max=%0d min=%0d, want all 0",
                bus12.address, bus12.sum, bus12.max_lvl, bus12.min_lvl);
        end
        rst = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic check_walk_results(input string name, input int vcyc);
        int es, emx, emn;
        n_checks++;
        if (vcyc !== T + 2) begin
            n_fail++; $display("FAIL %s_latency: valid at cycle %0d, want %0d", name, vcyc, T + 2);
        end
        n_checks++;
        if (got_v8 !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid8: narrow valid %b, want 1", name, got_v8);
        end
        for (int d = 0; d < 2; d++) begin
            model(d == 0 ? 12 : 8, es, emx, emn);
            n_checks++;
            if (got_sum[d] !== es || got_max[d] !== emx || got_min[d] !== emn) begin
                n_fail++; $display("FAIL %s_stats_w%0d: sum/max/min %0d/%0d/%0d, want %0d/%0d/%0d",
                    name, d == 0 ? 12 : 8, got_sum[d], got_max[d], got_min[d], es, emx, emn);
            end
        end
        n_checks++;
        if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_pulse: after valid valid=%b busy=%b, want 0/0", name, post_valid, post_busy);
        end
        $display("%s: valid@%0d sum=%0d max=%0d min=%0d (w8 sum=%0d)",
            name, vcyc, got_sum[0], got_max[0], got_min[0], got_sum[1]);
    endtask

    task automatic test_all_neg();
        int vcyc;
        for (int k = 0; k < T; k++) rom[k] = 6'h3F;
        run_walk(1'b0, vcyc);
        check_walk_results("all_neg", vcyc);
        n_checks++;
        if (got_sum[0] !== -64 || got_max[0] !== 0 || got_min[0] !== -64) begin
            n_fail++; $display("FAIL all_neg_const: %0d/%0d/%0d, want -64/0/-64", got_sum[0], got_max[0], got_min[0]);
        end
        n_checks++;
        if (busy_gap !== 1'b0) begin
            n_fail++; $display("FAIL all_neg_busy: busy dropped during walk, want continuous busy");
        end
    endtask

    task automatic test_all_pos();
        int vcyc, bad, first_bad;
        for (int k = 0; k < T; k++) rom[k] = 6'd31;
        run_walk(1'b0, vcyc);
        check_walk_results("all_pos", vcyc);
        bad = 0; first_bad = -1;
        for (int k = 0; k < addr_seen.size(); k++)
            if (addr_seen[k] != k) begin bad++; if (first_bad < 0) first_bad = k; end
        n_checks++;
        if (bad !== 0 || addr_seen.size() !== T) begin
            n_fail++; $display("FAIL all_pos_addr: %0d wrong of %0d (first at cycle %0d), want 0..63 in order",
                bad, addr_seen.size(), first_bad + 1);
        end
        n_checks++;
        if (got_sum[0] !== 1984 || got_max[0] !== 1984 || got_min[0] !== 0) begin
            n_fail++; $display("FAIL all_pos_const: %0d/%0d/%0d, want 1984/1984/0", got_sum[0], got_max[0], got_min[0]);
        end
        n_checks++;
`ifdef PATH_WALKER_SATURATE_EN
        if (got_sum[1] !== 127 || got_max[1] !== 127) begin
            n_fail++; $display("FAIL all_pos_w8: sum=%0d max=%0d, want 127/127", got_sum[1], got_max[1]);
        end
`else
        if (got_sum[1] !== -64) begin
            n_fail++; $display("FAIL all_pos_w8: sum=%0d, want -64", got_sum[1]);
        end
`endif
    endtask

    task automatic test_alternate();
        int vcyc;
        for (int k = 0; k < T; k++) rom[k] = (k % 2 == 0) ? 6'd1 : 6'h3F;
        run_walk(1'b0, vcyc);
        check_walk_results("alternate", vcyc);
        n_checks++;
        if (got_sum[0] !== 0 || got_max[0] !== 1 || got_min[0] !== 0) begin
            n_fail++; $display("FAIL alternate_const: %0d/%0d/%0d, want 0/1/0", got_sum[0], got_max[0], got_min[0]);
        end
    endtask

    task automatic test_random();
        int vcyc, es, emx, emn;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < T; k++) rom[k] = 6'($urandom);
            run_walk(1'b0, vcyc);
            check_walk_results($sformatf("random%0d", it), vcyc);
            repeat (4) @(posedge clk);
            #1;
            model(12, es, emx, emn);
            n_checks++;
            if (int'(bus12.sum) !== es || int'(bus12.max_lvl) !== emx || int'(bus12.min_lvl) !== emn) begin
                n_fail++; $display("FAIL random%0d_hold: %0d/%0d/%0d in idle, want %0d/%0d/%0d",
                    it, bus12.sum, bus12.max_lvl, bus12.min_lvl, es, emx, emn);
            end
        end
    endtask

    task automatic test_reset_mid();
        int vcyc, nvalid;
        bit found;
        for (int k = 0; k < T; k++) rom[k] = 6'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            start = 1'b0;
            if (bus12.address == 6'd20) begin found = 1'b1; break; end
            @(posedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL reset_mid_reach: address 20 not seen, want it within walk");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus12.busy !== 1'b0 || bus12.valid !== 1'b0 || bus12.address !== 6'd0 || bus12.sum !== 12'sd0
            || bus12.max_lvl !== 12'sd0 || bus12.min_lvl !== 12'sd0 || bus8.sum !== 8'sd0) begin
            n_fail++; $display("FAIL reset_mid_clear: busy=%b valid=%b addr=%0d sum=%0d max=%0d min=%0d, want 0s",
                bus12.busy, bus12.valid, bus12.address, bus12.sum, bus12.max_lvl, bus12.min_lvl);
        end
        nvalid = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus12.valid || bus8.valid) nvalid++;
        end
        n_checks++;
        if (nvalid !== 0) begin
            n_fail++; $display("FAIL reset_mid_novalid: %0d valid cycles, want 0", nvalid);
        end
        $display("reset_mid: cleared at address 20, %0d spurious valids", nvalid);
        run_walk(1'b0, vcyc);
        check_walk_results("after_reset", vcyc);
    endtask

    task automatic test_start_held();
        int vcyc, v2, nvalid;
        bit busy68;
        for (int k = 0; k < T; k++) rom[k] = 6'($urandom);
        run_walk(1'b1, vcyc);
        check_walk_results("held_first", vcyc);
        v2 = -1; nvalid = 0; busy68 = 1'b0;
        for (int c = T + 4; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (c == T + 4) busy68 = bus12.busy;
            if (bus12.valid) begin nvalid++; v2 = c; break; end
        end
        start = 1'b0;
        n_checks++;
        if (busy68 !== 1'b1) begin
            n_fail++; $display("FAIL held_restart: busy=%b at cycle %0d, want 1", busy68, T + 4);
        end
        n_checks++;
        if (v2 !== 2 * (T + 2) + 1 || nvalid !== 1) begin
            n_fail++; $display("FAIL held_second: second valid at cycle %0d, want %0d", v2, 2 * (T + 2) + 1);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (bus12.busy !== 1'b0) begin
            n_fail++; $display("FAIL held_idle: busy=%b after release, want 0", bus12.busy);
        end
        $display("start_held: first valid@%0d second valid@%0d", vcyc, v2);
    endtask

    initial begin
        test_reset();
        test_all_neg();
        test_all_pos();
        test_alternate();
        test_random();
        test_reset_mid();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
